dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the target end of the MEM-stage load/store interface.
//  It accepts one word read or write per request and answers with a single-cycle ack after
//  a fixed latency. While an access is pending it drives stall_o so the pipeline freezes.
//  It replaces the single-cycle data memory for latency/stall experiments and is the

---
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word data memory with ready/ack handshake and pipeline stall.
// Optional DMEM_ALIGN_CHECK_EN: misaligned accesses raise err_o, suppress writes, read as zero.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          bad_q;
    logic          misaligned;
    logic          fire;
    logic          mem_we;
    logic          unused_addr;
    logic [31:0]   mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |addr_i[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits wrap away; low byte-offset bits only matter for the alignment check.
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign stall_o = req_i & ~ack_o;
    assign fire    = (state == BUSY) && (cnt == CW'(1));
    assign mem_we  = fire && we_q && !bad_q;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_o <= 1'b1;
            ack_o   <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_i[AW+1:2];
                        wdata_q <= wdata_i;
                        bad_q   <= misaligned;
                        cnt     <= CW'(LATENCY);
                        ready_o <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        ack_o <= 1'b1;
                        err_o <= bad_q;
                        if (!we_q) begin
                            rdata_o <= bad_q ? '0 : mem[idx_q];
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack_o   <= 1'b0;
                    err_o   <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ack_o   <= 1'b0;
                    err_o   <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized accesses
// checked cycle by cycle against a word-array reference model.
module tb_dmem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 4;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b0;
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [31:0] addr_i  = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, ack_o, stall_o, err_o;
    logic [31:0] rdata_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    bit          valid_m [DEPTH];
    logic [31:0] rdata_m = '0;
    bit          rdata_known = 1'b1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .ready_o(ready_o),
        .ack_o  (ack_o),
        .rdata_o(rdata_o),
        .stall_o(stall_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // One complete access starting at a negedge in IDLE; ends at the negedge of the IDLE cycle after ack.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input bit pulse);
        int idx;
        bit bad;
        idx = int'((a / 4) % DEPTH);
        bad = misaligned(a);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        #1;
        checks++;
        if (ready_o !== 1'b1 || ack_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_idle: ready=%b ack=%b stall=%b required 1 0 1", ready_o, ack_o, stall_o);
        end
        @(posedge clk_i); #1;
        if (pulse) req_i = 1'b0;
        we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
        for (int c = 1; c <= LATENCY; c++) begin
            @(negedge clk_i);
            checks++;
            if (ack_o !== 1'b0 || ready_o !== 1'b0 || stall_o !== req_i || err_o !== 1'b0 ||
                (rdata_known && rdata_o !== rdata_m)) begin
                errors++;
                $display("FAIL busy_cycle%0d: ack=%b ready=%b stall=%b err=%b rdata=%h required 0 0 %b 0 %h",
                         c, ack_o, ready_o, stall_o, err_o, rdata_o, req_i, rdata_m);
            end
        end
        if (w) begin
            if (!bad) begin
                mem_m[idx] = d;
                valid_m[idx] = 1'b1;
            end
        end else if (bad) begin
            rdata_m = '0;
            rdata_known = 1'b1;
        end else begin
            rdata_m = mem_m[idx];
            rdata_known = valid_m[idx];
        end
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b1 || ready_o !== 1'b0 || stall_o !== 1'b0 || err_o !== bad ||
            (rdata_known && rdata_o !== rdata_m)) begin
            errors++;
            $display("FAIL ack_cycle: ack=%b ready=%b stall=%b err=%b rdata=%h required 1 0 0 %b %h",
                     ack_o, ready_o, stall_o, err_o, rdata_o, bad, rdata_m);
        end
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || ready_o !== 1'b1 || err_o !== 1'b0 || (rdata_known && rdata_o !== rdata_m)) begin
            errors++;
            $display("FAIL after_ack: ack=%b ready=%b err=%b rdata=%h required 0 1 0 %h",
                     ack_o, ready_o, err_o, rdata_o, rdata_m);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (ready_o !== 1'b1 || ack_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b ack=%b rdata=%h err=%b stall=%b required 1 0 0 0 0",
                     ready_o, ack_o, rdata_o, err_o, stall_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_latency();
        access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);
        req_i = 1'b0;
        checks++;
        if (rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL latency_readback: rdata=%h required deadbeef", rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 32'h40, 32'h11111111, 1'b1);
        access(1'b1, 32'h44, 32'h22222222, 1'b1);
        access(1'b1, 32'h48, 32'h33333333, 1'b1);
        access(1'b0, 32'h40, 32'h0, 1'b0);
        access(1'b0, 32'h44, 32'h0, 1'b0);
        access(1'b0, 32'h48, 32'h0, 1'b0);
        req_i = 1'b0;
    endtask

    task automatic test_early_release();
        access(1'b1, 32'h20, 32'hCAFEF00D, 1'b1);
        access(1'b0, 32'h20, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        access(1'b1, 32'h400, 32'h1234, 1'b1);
        access(1'b0, 32'h000, 32'h0, 1'b1);
        checks++;
        if (rdata_o !== 32'h1234) begin
            errors++;
            $display("FAIL wrap_readback: rdata=%h required 00001234", rdata_o);
        end
    endtask

    task automatic test_align();
        access(1'b1, 32'h10, 32'hAAAA5555, 1'b1);
        access(1'b1, 32'h13, 32'h0000FFFF, 1'b1);
        access(1'b0, 32'h10, 32'h0, 1'b1);
        access(1'b0, 32'h11, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] held;
        access(1'b0, 32'h10, 32'h0, 1'b1);
        held = mem_m[4];
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h0BAD0BAD;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        rdata_m = '0;
        rdata_known = 1'b1;
        checks++;
        if (ready_o !== 1'b1 || ack_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b ack=%b rdata=%h err=%b required 1 0 0 0",
                     ready_o, ack_o, rdata_o, err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < LATENCY + 2; c++) begin
            @(negedge clk_i);
            checks++;
            if (ack_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_no_ack: cycle %0d ack=%b ready=%b required 0 1", c, ack_o, ready_o);
            end
        end
        access(1'b0, 32'h10, 32'h0, 1'b1);
        checks++;
        if (rdata_o !== held) begin
            errors++;
            $display("FAIL reset_no_write: rdata=%h required %h", rdata_o, held);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int unsigned idx;
            logic [31:0] a;
            bit w;
            idx = $urandom_range(0, 15);
            a = ($urandom / (DEPTH * 4)) * (DEPTH * 4) + idx * 4 + $urandom_range(0, 3);
            w = ($urandom_range(0, 1) == 1) || !valid_m[idx];
            access(w, a, $urandom, 1'($urandom_range(0, 1)));
            req_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_early_release();
        test_wrap();
        test_align();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
